// File: rtl/counter_pkg.sv
// Shared constants for the updown_counter family: count-mode encodings and
// the RUN/DONE state encoding.
package counter_pkg;

    localparam logic [1:0] MODE_FREE     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_DONE = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: tick is high on every (div+1)-th enabled cycle.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_q, count_d;

    // div is compared live, so a count already past a newly lowered div ticks at once.
    assign tick = (count_q >= div);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Parametrised modulo up/down counter with free-run, one-shot and ping-pong modes.
// Define COUNTER_PRESCALE_EN to add the div port and clock-enable prescaler.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MODULUS    = 16,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic [1:0]            mode,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] div,
`endif
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  done,
    output logic                  dir
);

    localparam int unsigned      MAX_INT = MODULUS - 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_INT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             dir_q, dir_d;
    logic             state_q, state_d;

    logic             tick;
    logic [WIDTH-1:0] load_clamped;
    logic             at_term;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr | load),
        .div  (div),
        .tick (tick)
    );
`else
    logic unused_prescale_w;
    assign unused_prescale_w = (PRESCALE_W == 0);
    assign tick = 1'b1;
`endif

    assign load_clamped = (32'(load_val) > MAX_INT) ? MAX_VAL : load_val;
    assign at_term      = dir_q ? (out_q == MAX_VAL) : (out_q == '0);

    always_comb begin
        out_d   = out_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        dir_d   = dir_q;
        state_d = state_q;

        if (clr) begin
            out_d   = '0;
            state_d = ST_RUN;
            done_d  = 1'b0;
            dir_d   = up;
        end else if (load) begin
            out_d   = load_clamped;
            state_d = ST_RUN;
            done_d  = 1'b0;
            dir_d   = up;
        end else if (en) begin
            // Ping-pong owns dir; other modes simply follow the up input.
            if (mode != MODE_PINGPONG) begin
                dir_d = up;
            end
            if (tick && (state_q == ST_RUN)) begin
                if (at_term) begin
                    tc_d = 1'b1;
                    case (mode)
                        MODE_ONESHOT: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                        MODE_PINGPONG: begin
                            dir_d = ~dir_q;
                            out_d = dir_q ? out_q - ONE : out_q + ONE;
                        end
                        default: begin
                            out_d = dir_q ? '0 : MAX_VAL;
                        end
                    endcase
                end else begin
                    out_d = dir_q ? out_q + ONE : out_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b1;
            state_q <= ST_RUN;
        end else begin
            out_q   <= out_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            state_q <= state_d;
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign done = done_q;
    assign dir  = dir_q;

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised modulo up/down counter, successor to the fixed 4-bit free-running counter. Adds configurable width and modulus, direction control, synchronous load/clear, three count modes (free-run, one-shot, ping-pong), a terminal-count pulse and an optional clock-enable prescaler. Sits alongside the existing counter as the general-purpose timing/sequencing primitive for simulation projects and small FPGA designs.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range is 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- PRESCALE_W, 4: prescaler divisor width; used only with the prescaler compiled in.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes count and prescaler.
- up  in  1  direction: 1 = up, 0 = down.
- mode  in  2  00 free-run, 01 one-shot, 10 ping-pong, 11 treated as free-run.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value; values ≥ MODULUS clamp to MODULUS-1.
- div  in  PRESCALE_W  prescaler divisor; present only with COUNTER_PRESCALE_EN.
- out  out  WIDTH  registered count value.
- tc  out  1  registered terminal-count pulse.
- done  out  1  one-shot finished flag.
- dir  out  1  effective direction register (1 = up).

## Operation
- Reset (async): out=0, tc=0, done=0, dir=1, state RUN, prescaler count 0.
- Priority at each edge: clr > load > step. clr and load ignore en.
- clr: out←0, state←RUN, done←0, dir←up, tc←0, prescaler←0.
- load: out←clamp(load_val), state←RUN, done←0, dir←up, tc←0, prescaler←0.
- Step: occurs on an edge where en=1 and tick=1. tick=1 every enabled cycle when the prescaler is absent.
- Terminal value: MODULUS-1 when dir=1, 0 when dir=0.
- Direction: in modes 00, 01 and 11, dir←up every cycle. In mode 10, dir is captured from up only on clr or load, and toggles at the terminal value.
- A terminal event is a step taken while out equals the terminal value:
  - Free-run: wrap (MODULUS-1→0 up, 0→MODULUS-1 down).
  - One-shot: out holds, state←DONE, done←1.
  - Ping-pong: dir toggles and out moves one step in the new direction (e.g. 9→8 with MODULUS=10).
- Non-terminal step: out±1 according to dir.
- State machine RUN/DONE:
  - RUN→DONE only on a one-shot terminal event.
  - DONE→RUN only on clr or load.
  - In DONE, steps are ignored, tc stays 0 and out holds.
- Mode changes take effect at the next step. A mode change does not leave DONE.

## Timing
- out, tc, done and dir are all registered; there is no combinational input→output path.
- Latency: one cycle from step, clr or load to the updated out.
- tc is high for exactly one cycle, the cycle after the edge on which a terminal event occurred. It is coincident with the post-event out value.
- done rises in the same cycle as the one-shot tc and stays high until clr or load.
- en deasserted mid-count: out, dir and the prescaler hold. Counting resumes with no lost or extra step.
- rst asserted mid-operation clears all state immediately, independent of clk.

## Configuration
- COUNTER_PRESCALE_EN defined:
  - The div port exists.
  - tick=1 on every (div+1)-th enabled cycle; div=0 means every cycle.
  - Prescaler count resets on rst, clr and load.
  - div is compared live; a change applies from the current prescaler count. If the prescaler count is already ≥ the new div, the next enabled cycle ticks.
- Undefined: no div port, no prescaler logic, tick tied to 1.

## Structure
- Shared package counter_pkg holds:
  - Mode constants: MODE_FREE=2'b00, MODE_ONESHOT=2'b01, MODE_PINGPONG=2'b10.
  - State encoding: ST_RUN, ST_DONE.
- Sub-module counter_prescaler (clk, rst, en, clr, div → tick), instantiated only under COUNTER_PRESCALE_EN.

## Test plan
Unless stated otherwise, WIDTH=4 and MODULUS=10.
- rst pulse for 10 ns, then mode=00, up=1, en=1 → out counts 0..9,0. tc is high only in the cycle out=0 after 9.
- mode=00, up=0 after clr → out goes 0,9,8…; tc high in the cycle out=9 first appears.
- mode=01, load load_val=7, up=1 → out 7,8,9,9,9…; tc and done rise in the cycle after 9 is first stepped on. Further en has no effect; clr returns out=0, done=0.
- mode=10, up=1 from 0 → out 0..9,8..0,1; dir falls at the 9→8 reversal and rises at the 0→1 reversal; tc pulses at each reversal.
- load_val=15 → out=9 (clamped). Same-cycle clr+load → out=0. en toggled low for 3 cycles mid-count → out holds for 3 cycles. rst mid-count → out=0 asynchronously.
- With COUNTER_PRESCALE_EN, div=2 → out advances every 3rd enabled cycle. load resets the prescaler phase, so the first step comes 3 cycles after the load.
